// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - two-port arbiter sharing one multicycle signed 64-bit divider
module div_s64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] quo,
  output logic [63:0] r,
  output logic        ovf
);
  logic [63:0] ua, ub, uq, ur;

  // Magnitude division with sign fix-up; truncates toward zero, remainder takes dividend sign
  always_comb begin
    ua  = a[63] ? (~a + 64'd1) : a;
    ub  = b[63] ? (~b + 64'd1) : b;
    uq  = '0;
    ur  = '0;
    if (ub != 64'd0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    quo = (a[63] ^ b[63]) ? (~uq + 64'd1) : uq;
    r   = a[63] ? (~ur + 64'd1) : ur;
    ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
  end
endmodule

module div_arbiter #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_quo,
  output logic [63:0] resp_rem,
  output logic        resp_ovf,
  output logic        resp_dbz,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        prio_q, prio_d;
  logic        id_q, id_d;
  logic [63:0] a_q, a_d, b_q, b_d;
  logic [63:0] quo_q, quo_d, rem_q, rem_d;
  logic        ovf_q, ovf_d, dbz_q, dbz_d;

  logic        any_valid, gnt_id, idle_ok, xfer;
  logic [63:0] sel_a, sel_b;
  logic [63:0] div_quo, div_rem;
  logic        div_ovf;

  // Divider sees only the latched operands so it stays stable over the wait window
  div_s64 u_div (
    .a   (a_q),
    .b   (b_q),
    .quo (div_quo),
    .r   (div_rem),
    .ovf (div_ovf)
  );

  // Round-robin grant: prio wins a tie, a lone requester always wins
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    gnt_id     = (req0_valid & req1_valid) ? prio_q : req1_valid;
    idle_ok    = (state_q == IDLE) & ~rst;
    req0_ready = idle_ok & any_valid & ~gnt_id;
    req1_ready = idle_ok & any_valid & gnt_id;
    xfer       = idle_ok & any_valid;
    sel_a      = gnt_id ? req1_a : req0_a;
    sel_b      = gnt_id ? req1_b : req0_b;
  end

  // Next-state and datapath update for the IDLE/EXEC/DONE sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          id_d   = gnt_id;
          prio_d = ~gnt_id;
          a_d    = sel_a;
          b_d    = sel_b;
          if (sel_b != 64'd0) begin
            state_d = EXEC;
            cnt_d   = 8'(WAIT_CYCLES - 1);
          end else begin
            state_d = DONE;
            quo_d   = 64'hFFFF_FFFF_FFFF_FFFF;
            rem_d   = sel_a;
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          quo_d   = div_quo;
          rem_d   = div_rem;
          ovf_d   = div_ovf;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_id    = id_q;
  assign resp_quo   = quo_q;
  assign resp_rem   = rem_q;
  assign resp_ovf   = ovf_q;
  assign resp_dbz   = dbz_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - scoreboard bench for div_arbiter
module tb_div_arbiter;
  localparam int W4 = 4;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [63:0] quo;
    logic [63:0] rem;
    logic        ovf;
    logic        dbz;
    int          hs;
  } exp_t;

  // DUT with WAIT_CYCLES=4
  logic        r0v, r0r, r1v, r1r, rv, rr, rid, rovf, rdbz, bsy;
  logic [63:0] r0a, r0b, r1a, r1b, rquo, rrem;
  // DUT with WAIT_CYCLES=1
  logic        s0v, s0r, s1v, s1r, sv, sr, sid, sovf, sdbz, sbsy;
  logic [63:0] s0a, s0b, s1a, s1b, squo, srem;

  div_arbiter #(.WAIT_CYCLES(W4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
    .resp_valid(rv), .resp_ready(rr), .resp_id(rid), .resp_quo(rquo),
    .resp_rem(rrem), .resp_ovf(rovf), .resp_dbz(rdbz), .busy(bsy)
  );

  div_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(s0v), .req0_ready(s0r), .req0_a(s0a), .req0_b(s0b),
    .req1_valid(s1v), .req1_ready(s1r), .req1_a(s1a), .req1_b(s1b),
    .resp_valid(sv), .resp_ready(sr), .resp_id(sid), .resp_quo(squo),
    .resp_rem(srem), .resp_ovf(sovf), .resp_dbz(sdbz), .busy(sbsy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic id, input logic [63:0] a, input logic [63:0] b, input int hs);
    exp_t   e;
    longint sa, sb;
    e.id = id; e.hs = hs; e.ovf = 1'b0; e.dbz = 1'b0;
    if (b == 64'd0) begin
      e.quo = 64'hFFFF_FFFF_FFFF_FFFF; e.rem = a; e.dbz = 1'b1;
    end else if (a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      e.quo = MIN64; e.rem = 64'd0; e.ovf = 1'b1;
    end else begin
      sa = a; sb = b;
      e.quo = sa / sb;
      e.rem = sa % sb;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard and reference grant model for dut4
  exp_t q4[$];
  logic arb_ids[$];
  int   cyc4 = 0, hs_cnt = 0, last_resp = 0;
  logic exp_busy = 1'b0, exp_prio = 1'b0, prev_v4 = 1'b0;
  logic arb_mode = 1'b0, gap_chk = 1'b0;

  always @(negedge clk) begin
    logic g, any;
    exp_t e;
    cyc4++;
    if (rst) begin
      q4.delete(); exp_busy = 1'b0; exp_prio = 1'b0; prev_v4 = 1'b0;
    end else begin
      check("busy", bsy, exp_busy);
      any = r0v | r1v;
      g   = (r0v & r1v) ? exp_prio : r1v;
      if (!exp_busy) check("ready_grant", {r0r, r1r}, any ? (g ? 2'b01 : 2'b10) : 2'b00);
      else           check("ready_busy", {r0r, r1r}, 2'b00);
      if (rv) begin
        if (q4.size() == 0) check("spurious_resp", 1, 0);
        else begin
          e = q4[0];
          if (!prev_v4) check("latency4", cyc4 - e.hs, e.dbz ? 1 : W4 + 1);
          check("resp4", {rid, rquo, rrem, rovf, rdbz}, {e.id, e.quo, e.rem, e.ovf, e.dbz});
          if (rr) begin
            void'(q4.pop_front());
            exp_busy  = 1'b0;
            last_resp = cyc4;
            if (arb_mode) arb_ids.push_back(rid);
          end
        end
      end
      prev_v4 = rv;
      if (!exp_busy && any && !(rv && rr) && ((r0v && r0r) || (r1v && r1r))) begin
        q4.push_back(model(g, g ? r1a : r0a, g ? r1b : r0b, cyc4));
        exp_busy = 1'b1;
        exp_prio = ~g;
        hs_cnt++;
        if (gap_chk) begin
          check("grant_gap", cyc4 - last_resp, 1);
          gap_chk = 1'b0;
        end
      end
    end
  end

  // Scoreboard for dut1
  exp_t q1[$];
  int   cyc1 = 0, hs1_cnt = 0;
  logic prev_v1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc1++;
    if (rst) begin
      q1.delete(); prev_v1 = 1'b0;
    end else begin
      if (sv) begin
        if (q1.size() == 0) check("spurious_resp1", 1, 0);
        else begin
          e = q1[0];
          if (!prev_v1) check("latency1", cyc1 - e.hs, e.dbz ? 1 : 2);
          check("resp1", {sid, squo, srem, sovf, sdbz}, {e.id, e.quo, e.rem, e.ovf, e.dbz});
          if (sr) void'(q1.pop_front());
        end
      end
      prev_v1 = sv;
      if (s0v && s0r) begin q1.push_back(model(1'b0, s0a, s0b, cyc1)); hs1_cnt++; end
      if (s1v && s1r) begin q1.push_back(model(1'b1, s1a, s1b, cyc1)); hs1_cnt++; end
    end
  end

  task automatic issue4(input logic p, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    if (p) begin r1a = a; r1b = b; r1v = 1'b1; end
    else   begin r0a = a; r0b = b; r0v = 1'b1; end
    #1;
    while (!(p ? r1r : r0r) && n < 100) begin step(); #1; n++; end
    if (n >= 100) check("issue_timeout", 1, 0);
    step();
    if (p) r1v = 1'b0; else r0v = 1'b0;
  endtask

  task automatic wait_idle4();
    int n = 0;
    while ((bsy || q4.size() != 0) && n < 300) begin step(); n++; end
    if (n >= 300) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_hs(input int tgt);
    int n = 0;
    while (hs_cnt < tgt && n < 300) begin step(); n++; end
    if (n >= 300) check("hs_timeout", 1, 0);
  endtask

  initial begin
    int n;
    logic p;
    logic [63:0] a, b;
    r0v = 0; r1v = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0; rr = 1;
    s0v = 0; s1v = 0; s0a = 0; s0b = 0; s1a = 0; s1b = 0; sr = 1;
    step(); step(); step();
    check("reset_state", {bsy, rv, rid, rquo, rrem, rovf, rdbz, r0r, r1r}, '0);
    rst = 1'b0;
    step();

    // single op
    issue4(1'b0, 64'd100, 64'd7);
    wait_idle4();

    // divide by zero
    issue4(1'b1, 64'h8000_0000_0000_0005, 64'd0);
    wait_idle4();

    // arbitration with both ports continuously valid
    arb_mode = 1'b1;
    r0a = -64'sd20; r0b = 64'sd3; r1a = 64'sd20; r1b = -64'sd3;
    r0v = 1'b1; r1v = 1'b1;
    n = hs_cnt + 4;
    wait_hs(n);
    r0v = 1'b0; r1v = 1'b0;
    wait_idle4();
    arb_mode = 1'b0;
    check("arb_count", arb_ids.size(), 4);
    for (int i = 0; i < arb_ids.size(); i++) check("arb_id", arb_ids[i], i % 2);

    // backpressure with req1 waiting
    rr = 1'b0;
    issue4(1'b0, 64'd1000, -64'sd9);
    r1a = -64'sd77; r1b = 64'sd5; r1v = 1'b1;
    n = 0;
    while (!rv && n < 50) begin step(); n++; end
    if (n >= 50) check("bp_valid_timeout", 1, 0);
    for (int i = 0; i < 10; i++) step();
    gap_chk = 1'b1;
    rr = 1'b1;
    n = hs_cnt + 1;
    wait_hs(n);
    r1v = 1'b0;
    wait_idle4();
    check("gap_checked", gap_chk, 1'b0);

    // reset in second EXEC cycle
    issue4(1'b0, 64'd500, 64'd3);
    step();
    rst = 1'b1;
    #1;
    check("rst_outputs", {bsy, rv, rid, rquo, rrem, rovf, rdbz, r0r, r1r}, '0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("no_aborted_resp", rv, 1'b0);
    r0a = 64'd9; r0b = 64'd2; r1a = 64'd33; r1b = 64'd4;
    r0v = 1'b1; r1v = 1'b1;
    #1;
    check("prio_after_reset", {r0r, r1r}, 2'b10);
    n = hs_cnt + 1;
    wait_hs(n);
    r0v = 1'b0; r1v = 1'b0;
    wait_idle4();

    // WAIT_CYCLES=1 sweep
    for (int i = 0; i < 50; i++) begin
      p = 1'($urandom_range(0, 1));
      if (i == 0)      begin a = MIN64; b = 64'hFFFF_FFFF_FFFF_FFFF; end
      else if (i == 1) begin a = MIN64; b = 64'd1; end
      else begin
        a = {$urandom, $urandom};
        b = (i % 3 == 0) ? 64'($signed(32'($urandom_range(0, 40)) - 32'sd20)) : {$urandom, $urandom};
        if (b == 64'd0) b = 64'd1;
      end
      if (p) begin s1a = a; s1b = b; s1v = 1'b1; end
      else   begin s0a = a; s0b = b; s0v = 1'b1; end
      n = 0;
      #1;
      while (!(p ? s1r : s0r) && n < 50) begin
        step(); sr = 1'($urandom_range(0, 1)); #1; n++;
      end
      if (n >= 50) check("sweep_issue_timeout", 1, 0);
      step();
      s0v = 1'b0; s1v = 1'b0;
      n = 0;
      while ((sbsy || q1.size() != 0) && n < 100) begin
        sr = 1'($urandom_range(0, 1)); step(); n++;
      end
      if (n >= 100) check("sweep_idle_timeout", 1, 0);
    end
    check("sweep_count", hs1_cnt, 50);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Sequencing and arbitration controller that shares one instance of the team's combinational 64-bit signed divider (ports a, b, r, quo, ovf) between two ALU issue ports. Operands are registered and held stable for a configurable multicycle window, then the divider outputs are captured. Results are returned on a single tagged response channel with valid/ready backpressure. Divide-by-zero is intercepted before the divider and answered without waiting out the window.

## Interface
- WAIT_CYCLES, 4, cycles the registered operands are held on the divider before capture; legal range 1..255.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  64 each  requester 0 dividend and divisor, two's complement.
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1.
- resp_valid  output  1  response held valid.
- resp_ready  input  1  consumer accepts the response.
- resp_id  output  1  index of the requester that issued the operation.
- resp_quo, resp_rem  output  64 each  captured quotient and remainder.
- resp_ovf  output  1  captured divider overflow flag.
- resp_dbz  output  1  divide-by-zero flag.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - Arbitrate among valid requesters. reqN_ready is combinational: high only in IDLE, and only for the granted requester. Transfer occurs when valid and ready are both high.
  - Arbitration is round-robin with a 1-bit prio pointer. If both requesters are valid, prio wins. If only one is valid, that one wins.
  - After any grant, prio becomes the index that was not granted.
  - On transfer: latch a, b and id.
    - If b != 0, go to EXEC with cnt = WAIT_CYCLES-1.
    - If b == 0, go to DONE with resp_quo = 64'hFFFF_FFFF_FFFF_FFFF, resp_rem = latched a, resp_dbz = 1, resp_ovf = 0.
- EXEC:
  - The divider inputs are driven only from the latched operand registers, never from request ports.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture divider quo, r and ovf into resp_quo, resp_rem and resp_ovf, set resp_dbz = 0, and go to DONE.
- DONE:
  - resp_valid = 1. All resp_* fields are stable until the handshake.
  - On resp_ready = 1, go to IDLE. The response fields keep their values. resp_valid falls.
  - No new request is accepted in the DONE cycle, even when resp_ready is high.
- Request ports are ignored outside IDLE. A requester holding valid keeps its operands stable until its ready is asserted.
- Reset (asynchronous, at any time, including mid-EXEC or DONE):
  - state = IDLE, cnt = 0, prio = 0.
  - All resp_* outputs = 0, resp_valid = 0, busy = 0, reqN_ready = 0 while rst is high.
  - An in-flight operation is discarded and produces no response.

## Timing
- Normal op, handshake in cycle T: EXEC occupies cycles T+1..T+WAIT_CYCLES. resp_valid is first high in cycle T+WAIT_CYCLES+1.
- Divide-by-zero, handshake in cycle T: resp_valid is high in cycle T+1.
- Response accepted in cycle D: IDLE is in D+1, and the earliest next accept is also D+1.
- Minimum issue interval with resp_ready held high:
  - normal op: WAIT_CYCLES+2 cycles;
  - divide-by-zero: 2 cycles.
- Backpressure: resp_valid stays high for any number of cycles until resp_ready. The controller stalls in DONE and never overwrites or drops a response.
- Simultaneous valid on both ports with continuous traffic: grants strictly alternate 0,1,0,1… starting with 0 after reset.

## Test plan
- Single op, WAIT_CYCLES=4: req0 a=100, b=7, resp_ready=1. Required:
  - req0_ready is high for exactly one cycle;
  - resp_valid rises 5 cycles later;
  - resp_id=0;
  - resp_quo, resp_rem and resp_ovf equal a reference divider instance driven with 100/7;
  - busy is high from the cycle after accept until the DONE handshake.
- Divide-by-zero: req1 a=64'h8000_0000_0000_0005, b=0. Required:
  - resp_valid rises in the next cycle;
  - resp_id=1, resp_dbz=1, resp_quo=64'hFFFF_FFFF_FFFF_FFFF, resp_rem=64'h8000_0000_0000_0005, resp_ovf=0.
- Arbitration: both requesters hold valid with distinct operands (a=-20, b=3 on req0; a=20, b=-3 on req1) for 4 operations. Required:
  - resp_id sequence is 0,1,0,1;
  - each response matches the reference divider for its operands;
  - the losing requester's ready never rises while it waits.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid, then 1. Required:
  - resp_* fields are constant throughout the stall;
  - no ready is asserted during the stall;
  - the next grant occurs exactly one cycle after the handshake.
- Reset mid-operation: assert rst in the second EXEC cycle. Required:
  - in the same cycle, with no clock edge needed: busy=0, resp_valid=0, all resp_* fields=0;
  - after rst is released, no response appears for the aborted op;
  - a fresh request on req1 with req0 also valid is granted to req0, because prio was reset to 0.
- WAIT_CYCLES=1 sweep of 50 random signed operand pairs with random resp_ready. Every response matches the reference divider, with latency exactly 2 cycles from handshake to resp_valid.
